iter_alu: RTL and testbench

- Parametrised, handshaked ALU that generalises the team's 16-bit combinational ALU to any power-of-two WIDTH.
- Adds multi-cycle operations: bit-serial shifts and a shift-add unsigned multiply.
- Sits between the register file and writeback. Operands arrive on a valid/ready input channel; results leave on a valid/ready output channel.
- Add and subtract use a WIDTH-parametrised Brent-Kung parallel-prefix adder.

---
 rtl/iter_alu.sv | 209 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked iterative ALU: Brent-Kung add/sub, bit-serial shifts, shift-add multiply
module bk_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LV = $clog2(W);

    logic [LV:0][W-1:0]   gu;
    logic [LV:0][W-1:0]   pu;
    logic [LV-1:0][W-1:0] gd;
    logic [LV-1:0][W-1:0] pd;
    logic [W:0]           c;

    assign gu[0] = x & y;
    assign pu[0] = x ^ y;

    for (genvar lv = 0; lv < LV; lv++) begin : g_up
        for (genvar i = 0; i < W; i++) begin : g_bit
            if ((i + 1) % (2 << lv) == 0) begin : g_op
                assign gu[lv+1][i] = gu[lv][i] | (pu[lv][i] & gu[lv][i-(1<<lv)]);
                assign pu[lv+1][i] = pu[lv][i] & pu[lv][i-(1<<lv)];
            end else begin : g_pass
                assign gu[lv+1][i] = gu[lv][i];
                assign pu[lv+1][i] = pu[lv][i];
            end
        end
    end

    // Down-sweep fills in the prefixes the up-sweep tree skipped.
    assign gd[0] = gu[LV];
    assign pd[0] = pu[LV];
    for (genvar lv = 0; lv < LV - 1; lv++) begin : g_dn
        localparam int D = 1 << (LV - 2 - lv);
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= 3 * D - 1 && (i + 1 - D) % (2 * D) == 0) begin : g_op
                assign gd[lv+1][i] = gd[lv][i] | (pd[lv][i] & gd[lv][i-D]);
                assign pd[lv+1][i] = pd[lv][i] & pd[lv][i-D];
            end else begin : g_pass
                assign gd[lv+1][i] = gd[lv][i];
                assign pd[lv+1][i] = pd[lv][i];
            end
        end
    end

    assign c    = {gd[LV-1] | (pd[LV-1] & {W{cin}}), cin};
    assign sum  = pu[0] ^ c[W-1:0];
    assign cout = c[W];
endmodule

module iter_alu #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       alu_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             overflow,
    output logic             busy
);
    localparam logic [4:0] OP_ADD  = 5'b00000, OP_ADDU = 5'b00001, OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SUBU = 5'b00011, OP_INC  = 5'b00100, OP_DEC  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b01000, OP_OR   = 5'b01001, OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOT  = 5'b01011, OP_SLT  = 5'b10100, OP_SLTU = 5'b10101;
    localparam logic [4:0] OP_SLL  = 5'b10000, OP_SRL  = 5'b10001, OP_SRA  = 5'b10010;
    localparam logic [4:0] OP_MULU = 5'b11000;
    localparam logic [SHW:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic [SHW:0]       count;
    logic [4:0]         code_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   work;
    logic               sh_ov;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   add_y, sum, res, work_next;
    logic               add_cin, cout, s_ov, res_ov, sat, is_shift, go_exec, sh_ov_next;
    logic [SHW:0]       n;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign in_ready = (state == IDLE) && !rst;
    assign n        = {1'b0, B[SHW-1:0]};
    assign sat      = |B[WIDTH-1:SHW];
    assign is_shift = (alu_code == OP_SLL) || (alu_code == OP_SRL) || (alu_code == OP_SRA);
    assign go_exec  = (is_shift && !sat && n != '0) || (alu_code == OP_MULU);

    // One adder serves every arithmetic op; subtraction-like ops feed ~B with carry-in.
    always_comb begin
        add_y   = B;
        add_cin = 1'b0;
        case (alu_code)
            OP_SUB, OP_SUBU, OP_SLT, OP_SLTU: begin add_y = ~B; add_cin = 1'b1; end
            OP_INC:  begin add_y = '0; add_cin = 1'b1; end
            OP_DEC:  add_y = '1;
            default: ;
        endcase
    end

    bk_adder #(.W(WIDTH)) u_add (.x(A), .y(add_y), .cin(add_cin), .sum(sum), .cout(cout));

    assign s_ov = (A[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        res    = '0;
        res_ov = 1'b0;
        case (alu_code)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin res = sum; res_ov = s_ov; end
            OP_ADDU: begin res = sum; res_ov = cout; end
            OP_SUBU: begin res = sum; res_ov = !cout; end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NOT:  res = ~A;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ s_ov};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, !cout};
            OP_SLL:  begin res = sat ? '0 : A; res_ov = sat && (|A); end
            OP_SRL:  res = sat ? '0 : A;
            OP_SRA:  res = sat ? {WIDTH{A[WIDTH-1]}} : A;
            default: ;
        endcase
    end

    always_comb begin
        work_next = work;
        case (code_r)
            OP_SLL:  work_next = work << 1;
            OP_SRL:  work_next = work >> 1;
            default: work_next = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

    assign sh_ov_next = sh_ov | ((code_r == OP_SLL) & work[WIDTH-1]);
    assign mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    assign prod_next  = {mul_sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            C         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            code_r    <= '0;
            a_r       <= '0;
            work      <= '0;
            sh_ov     <= 1'b0;
            prod      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= A;
                    code_r <= alu_code;
                    if (go_exec) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                        work  <= A;
                        sh_ov <= 1'b0;
                        prod  <= {{WIDTH{1'b0}}, B};
                        count <= (alu_code == OP_MULU) ? (SHW+1)'(WIDTH) : n;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        C         <= res;
                        overflow  <= res_ov;
                    end
                end
                EXEC: begin
                    count <= count - 1'b1;
                    work  <= work_next;
                    sh_ov <= sh_ov_next;
                    prod  <= prod_next;
                    if (count == CNT_ONE) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        if (code_r == OP_MULU) begin
                            C        <= prod_next[WIDTH-1:0];
                            overflow <= |prod_next[2*WIDTH-1:WIDTH];
                        end else begin
                            C        <= work_next;
                            overflow <= sh_ov_next;
                        end
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - directed self-checking bench for iter_alu
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [4:0]  alu_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] C;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  code;
        logic [15:0] c;
        logic        ov;
        int          lat;
        int          bz;
    } vec_t;

    iter_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .alu_code(alu_code), .out_valid(out_valid),
        .out_ready(out_ready), .C(C), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] code,
                          output int lat, output int bz);
        in_valid = 1'b1; A = a; B = b; alu_code = code;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; bz = 0;
        while (!out_valid && lat < 100) begin
            bz += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (C !== 16'h0) begin n_fail++; $display("FAIL reset_c: got %h exp 0000", C); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hi: got %b exp 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_lo: got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t v [0:8];
        int lat, bz;
        v[0] = '{16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 1'b1, 1, 0};
        v[1] = '{16'hFFFF, 16'h0001, 5'b00001, 16'h0000, 1'b1, 1, 0};
        v[2] = '{16'h0003, 16'h0005, 5'b00011, 16'hFFFE, 1'b1, 1, 0};
        v[3] = '{16'h0003, 16'h0005, 5'b00010, 16'hFFFE, 1'b0, 1, 0};
        v[4] = '{16'h7FFF, 16'h1234, 5'b00100, 16'h8000, 1'b1, 1, 0};
        v[5] = '{16'h8000, 16'h1234, 5'b00101, 16'h7FFF, 1'b1, 1, 0};
        v[6] = '{16'hFFFF, 16'h0001, 5'b10100, 16'h0001, 1'b0, 1, 0};
        v[7] = '{16'hFFFF, 16'h0001, 5'b10101, 16'h0000, 1'b0, 1, 0};
        v[8] = '{16'h0005, 16'hFFFE, 5'b00000, 16'h0003, 1'b0, 1, 0};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].a, v[i].b, v[i].code, lat, bz);
            n_checks++; if (C !== v[i].c) begin n_fail++; $display("FAIL arith[%0d]_c: got %h exp %h", i, C, v[i].c); end
            n_checks++; if (overflow !== v[i].ov) begin n_fail++; $display("FAIL arith[%0d]_ov: got %b exp %b", i, overflow, v[i].ov); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL arith[%0d]_lat: got %0d exp %0d", i, lat, v[i].lat); end
            consume();
        end
    endtask

    task automatic test_logic();
        vec_t v [0:5];
        int lat, bz;
        v[0] = '{16'hF0F0, 16'h3C3C, 5'b01000, 16'h3030, 1'b0, 1, 0};
        v[1] = '{16'hF0F0, 16'h3C3C, 5'b01001, 16'hFCFC, 1'b0, 1, 0};
        v[2] = '{16'hF0F0, 16'h3C3C, 5'b01010, 16'hCCCC, 1'b0, 1, 0};
        v[3] = '{16'h00FF, 16'h1234, 5'b01011, 16'hFF00, 1'b0, 1, 0};
        v[4] = '{16'hFFFF, 16'hFFFF, 5'b00110, 16'h0000, 1'b0, 1, 0};
        v[5] = '{16'h7FFF, 16'h7FFF, 5'b11111, 16'h0000, 1'b0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].code, lat, bz);
            n_checks++; if (C !== v[i].c) begin n_fail++; $display("FAIL logic[%0d]_c: got %h exp %h", i, C, v[i].c); end
            n_checks++; if (overflow !== v[i].ov) begin n_fail++; $display("FAIL logic[%0d]_ov: got %b exp %b", i, overflow, v[i].ov); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL logic[%0d]_lat: got %0d exp %0d", i, lat, v[i].lat); end
            consume();
        end
    endtask

    task automatic test_shift();
        vec_t v [0:7];
        int lat, bz;
        v[0] = '{16'h8000, 16'h0003, 5'b10010, 16'hF000, 1'b0, 4, 3};
        v[1] = '{16'h8000, 16'h0014, 5'b10010, 16'hFFFF, 1'b0, 1, 0};
        v[2] = '{16'h4001, 16'h0002, 5'b10000, 16'h0004, 1'b1, 3, 2};
        v[3] = '{16'h8000, 16'h000F, 5'b10001, 16'h0001, 1'b0, 16, 15};
        v[4] = '{16'h1234, 16'h0000, 5'b10000, 16'h1234, 1'b0, 1, 0};
        v[5] = '{16'h0001, 16'h0010, 5'b10000, 16'h0000, 1'b1, 1, 0};
        v[6] = '{16'hFFFF, 16'hFFFF, 5'b10001, 16'h0000, 1'b0, 1, 0};
        v[7] = '{16'h00F0, 16'h0004, 5'b10000, 16'h0F00, 1'b0, 5, 4};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].a, v[i].b, v[i].code, lat, bz);
            n_checks++; if (C !== v[i].c) begin n_fail++; $display("FAIL shift[%0d]_c: got %h exp %h", i, C, v[i].c); end
            n_checks++; if (overflow !== v[i].ov) begin n_fail++; $display("FAIL shift[%0d]_ov: got %b exp %b", i, overflow, v[i].ov); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL shift[%0d]_lat: got %0d exp %0d", i, lat, v[i].lat); end
            n_checks++; if (bz !== v[i].bz) begin n_fail++; $display("FAIL shift[%0d]_busy: got %0d exp %0d", i, bz, v[i].bz); end
            consume();
        end
    endtask

    task automatic test_mulu();
        vec_t v [0:3];
        int lat, bz;
        v[0] = '{16'h0100, 16'h0100, 5'b11000, 16'h0000, 1'b1, 17, 16};
        v[1] = '{16'h00FF, 16'h0101, 5'b11000, 16'hFFFF, 1'b0, 17, 16};
        v[2] = '{16'h0003, 16'h0005, 5'b11000, 16'h000F, 1'b0, 17, 16};
        v[3] = '{16'hFFFF, 16'hFFFF, 5'b11000, 16'h0001, 1'b1, 17, 16};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].a, v[i].b, v[i].code, lat, bz);
            n_checks++; if (C !== v[i].c) begin n_fail++; $display("FAIL mulu[%0d]_c: got %h exp %h", i, C, v[i].c); end
            n_checks++; if (overflow !== v[i].ov) begin n_fail++; $display("FAIL mulu[%0d]_ov: got %b exp %b", i, overflow, v[i].ov); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL mulu[%0d]_lat: got %0d exp %0d", i, lat, v[i].lat); end
            n_checks++; if (bz !== v[i].bz) begin n_fail++; $display("FAIL mulu[%0d]_busy: got %0d exp %0d", i, bz, v[i].bz); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat, bz;
        run_op(16'hF0F0, 16'h3C3C, 5'b01000, lat, bz);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL bp_lat: got %0d exp 1", lat); end
        in_valid = 1'b1; A = 16'h0001; B = 16'h0001; alu_code = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (C !== 16'h3030) begin n_fail++; $display("FAIL bp_hold_c[%0d]: got %h exp 3030", i, C); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b exp 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready[%0d]: got %b exp 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b exp 1", in_ready); end
        n_checks++; if (C !== 16'h3030) begin n_fail++; $display("FAIL bp_release_c: got %h exp 3030", C); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_abort();
        int lat, bz;
        in_valid = 1'b1; A = 16'h1234; B = 16'h5678; alu_code = 5'b11000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b exp 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", busy); end
        n_checks++; if (C !== 16'h0) begin n_fail++; $display("FAIL abort_c: got %h exp 0000", C); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready_hi: got %b exp 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready_lo: got %b exp 1", in_ready); end
        run_op(16'h0002, 16'h0003, 5'b00000, lat, bz);
        n_checks++; if (C !== 16'h0005) begin n_fail++; $display("FAIL abort_add_c: got %h exp 0005", C); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_add_ov: got %b exp 0", overflow); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL abort_add_lat: got %0d exp 1", lat); end
        consume();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_mulu();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
